// File: rtl/pipe_muldiv_ctrl_pkg.sv
// Shared encodings for the execute-stage multiply/divide sequencer.
package pipe_muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Divide keeps the remainder in the upper half and shifts quotient bits into
  // the lower half; the new quotient bit is returned separately (bit 0 left 0).
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : '0)};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, operand};
    q_bit    = 1'b0;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      q_bit    = ~diff[WIDTH];
      acc_next = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                  acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall request.
module pipe_muldiv_ctrl
  import pipe_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state;
  op_e                op_q;
  logic [CNT_W-1:0]   cnt;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_orig;
  logic [2*WIDTH-1:0] acc;

  logic               st_signed;
  logic               st_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;

  logic               fix_signed;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign stall = busy & (start | rd_hilo | mthi | mtlo);

  always_comb begin
    st_signed = op_is_signed(op_e'(op));
    st_div    = op_is_div(op_e'(op));
    a_neg     = st_signed & a[WIDTH-1];
    b_neg     = st_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .is_div   (op_is_div(op_q)),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Remainder follows the dividend sign, quotient/product follow sign_a^sign_b.
  always_comb begin
    fix_signed = op_is_signed(op_q);
    prod_fix   = (fix_signed && (sign_a ^ sign_b)) ? -acc : acc;
    q_fix      = (fix_signed && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix      = (fix_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= ST_IDLE;
      op_q   <= OP_MULT;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      opnd   <= '0;
      a_orig <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            op_q   <= op_e'(op);
            sign_a <= a_neg;
            sign_b <= b_neg;
            b_zero <= (b == '0);
            a_orig <= a;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
            if (st_div) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end
        end
        ST_RUN: begin
          acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_is_div(op_q)) begin
            if (b_zero) begin
              lo <= '1;
              hi <= a_orig;
              dz <= 1'b1;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Directed bench for pipe_muldiv_ctrl: result table plus stall/reset/HI-LO write sequences.
module tb_pipe_muldiv_ctrl;
  import pipe_muldiv_ctrl_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             clrn;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_hilo;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             stall;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[14];

  pipe_muldiv_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_hilo (rd_hilo),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .dz      (dz),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz);
    op = o; a = va; b = vb; start = 1'b1;
    tick;
    start = 1'b0;
    chk({name, " busy_after_start"}, busy, 1);
    repeat (WIDTH) tick;
    chk({name, " busy_before_fix"}, busy, 1);
    chk({name, " done_early"}, done, 0);
    tick;
    chk({name, " done"}, done, 1);
    chk({name, " busy_end"}, busy, 0);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
    chk({name, " dz"}, dz, edz);
    tick;
    chk({name, " done_pulse"}, done, 0);
    chk({name, " dz_clear"}, dz, 0);
  endtask

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{OP_MULTU, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
    vecs[11] = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[12] = '{OP_DIVU,  32'h80000000, 32'h10,       32'h00000000, 32'h08000000, 1'b0};
    vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};

    clrn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    rd_hilo = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    #17;
    chk("reset busy", busy, 0);
    chk("reset stall", stall, 0);
    chk("reset done", done, 0);
    chk("reset dz", dz, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    clrn = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // MTHI/MTLO in IDLE
    mthi = 1'b1; wdata = 32'h12345678;
    tick;
    mthi = 1'b0;
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi done", done, 0);
    mtlo = 1'b1; wdata = 32'hCAFEF00D;
    tick;
    mtlo = 1'b0;
    chk("mtlo lo", lo, 32'hCAFEF00D);
    chk("mtlo done", done, 0);

    // rd_hilo and a re-presented start held from edge 3 of a MULTU
    op = OP_MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    rd_hilo = 1'b1; start = 1'b1; a = 32'd6; b = 32'd7;
    #1;
    chk("stall edge2", stall, 1);
    for (int e = 3; e <= WIDTH; e++) begin
      tick;
      chk($sformatf("stall edge%0d", e), stall, 1);
    end
    tick;
    chk("stall busy_fell", busy, 0);
    chk("stall released", stall, 0);
    chk("stall first lo", lo, 32'd15);
    chk("stall first done", done, 1);
    tick;
    start = 1'b0; rd_hilo = 1'b0;
    chk("represent accepted", busy, 1);
    repeat (WIDTH) tick;
    tick;
    chk("represent lo", lo, 32'd42);
    chk("represent hi", hi, 32'd0);
    chk("represent done", done, 1);

    // MTLO while busy is stalled, not performed
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    tick;
    start = 1'b0; mtlo = 1'b1; wdata = 32'hDEADBEEF;
    #1;
    chk("mtlo busy stall", stall, 1);
    repeat (5) tick;
    chk("mtlo busy no write", lo, 32'd42);
    mtlo = 1'b0;
    repeat (28) tick;
    chk("mtlo busy result lo", lo, 32'd14);
    chk("mtlo busy result hi", hi, 32'd2);

    // start together with mthi: write now, result overwrites later
    op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1; mthi = 1'b1; wdata = 32'hAAAA5555;
    tick;
    start = 1'b0; mthi = 1'b0;
    chk("start+mthi hi", hi, 32'hAAAA5555);
    chk("start+mthi busy", busy, 1);
    repeat (WIDTH) tick;
    tick;
    chk("start+mthi final hi", hi, 32'd0);
    chk("start+mthi final lo", lo, 32'd12);

    // asynchronous reset at RUN step 10 of a DIV
    mthi = 1'b1; wdata = 32'h11111111;
    tick;
    mthi = 1'b0;
    op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    rd_hilo = 1'b1;
    #1;
    chk("abort pre stall", stall, 1);
    #1 clrn = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort stall", stall, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    chk("abort done", done, 0);
    #2 clrn = 1'b1; rd_hilo = 1'b0;
    run_op("post_reset", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_muldiv_ctrl.md
Name: pipe_muldiv_ctrl

Overview:
Sequences multi-cycle MULT/MULTU/DIV/DIVU for the execute stage, one radix-2 step per clock, and owns the HI/LO registers.
Drives a stall request so the pipeline freezes when a new mul/div, HI/LO read or HI/LO write arrives while an operation is in flight.
Operands come from the execute-stage register read values. HI/LO feed the execute writeback mux for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, step counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
clrn  input  1  asynchronous active-low reset
start  input  1  mul/div issue strobe from execute stage
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
a  input  WIDTH  operand rs (dividend / multiplicand)
b  input  WIDTH  operand rt (divisor / multiplier)
rd_hilo  input  1  MFHI/MFLO in execute stage
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight
stall  output  1  pipeline freeze request
done  output  1  one-cycle pulse, HI/LO just updated by an operation
dz  output  1  divide-by-zero flag, valid with done
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: single clock clk. clrn is asynchronous and active-low. While clrn=0: state=IDLE, hi=lo=0, busy=done=dz=stall=0, counter=0. This aborts any operation immediately with no partial HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE: on a clock edge with start=1, latch op and the operand magnitudes. Signed ops take absolute values and record sign_a/sign_b; unsigned ops use operands as-is. Clear the accumulator and counter; next state RUN.
- RUN: one step per edge. Multiply: shift-add on a 2*WIDTH accumulator. Divide: restoring shift-subtract on a WIDTH+1 partial remainder. Counter increments each edge. After WIDTH steps (counter == WIDTH-1 at the edge), next state FIX.
- FIX: one edge applies sign correction and writes HI/LO.
  - Signed multiply: negate the 2*WIDTH product if sign_a^sign_b.
  - Signed divide: negate the quotient if sign_a^sign_b; the remainder takes sign_a.
  - Next state IDLE; done=1 for exactly the following cycle.
- Latency: start sampled at edge 0; HI/LO hold the result after edge WIDTH+1 (edge 33 for WIDTH=32). busy=1 from after edge 0 until edge WIDTH+1.
- stall = busy & (start | rd_hilo | mthi | mtlo). Combinational, no register; zero when not busy.
- start while busy: ignored. The stall holds the issuing instruction, which is re-presented and accepted in the cycle busy falls.
- MTHI/MTLO in IDLE: write on the next edge. Simultaneous start and mthi/mtlo: the mthi/mtlo write occurs, and the result of the started operation later overwrites it. While busy, MTHI/MTLO are stalled, not performed.
- Divide by zero (b==0, signed or unsigned): lo=all ones, hi=a (original, un-negated), dz=1 with done. The divide still takes full latency. dz=0 in all other cases.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No flag.
- done is not asserted by MTHI/MTLO writes.

Decomposition:
- Shared package holds the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state encodings (ST_IDLE, ST_RUN, ST_FIX).
- One sub-module, muldiv_step: purely combinational single iteration. It takes the accumulator/remainder, operand and mode, and returns the next accumulator/remainder plus the quotient bit.
- Counter, FSM and HI/LO registers stay in pipe_muldiv_ctrl.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after edge 33: hi=0xFFFFFFFE, lo=0x00000001, done=1 for one cycle, busy=0.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=7 -> lo=14, hi=2, dz=0. DIV a=5 b=0 -> lo=0xFFFFFFFF, hi=5, dz=1 with done.
- rd_hilo=1 held from edge 3 of a MULTU -> stall=1 through the cycle before busy falls; stall=0 when busy=0. A start re-presented then is accepted.
- IDLE: mthi=1, wdata=0x12345678 -> hi=0x12345678 next edge, done=0. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- clrn pulled low at RUN step 10 of a DIV -> busy, stall, hi and lo all 0 immediately (asynchronous). After release, a new MULTU 3*4 gives lo=12, hi=0 at the full latency.
